// File: rtl/cache_ctrl_pkg.sv
// Shared types, constants and PLRU helpers for the cache controller.
package cache_ctrl_pkg;

   localparam int TAG_W   = 22;
   localparam int INDEX_W = 8;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOOKUP   = 3'd1,
      S_COMPARE  = 3'd2,
      S_MEM_RD   = 3'd3,
      S_MEM_WAIT = 3'd4,
      S_FILL     = 3'd5,
      S_WRITE    = 3'd6,
      S_RESP     = 3'd7
   } state_t;

   typedef logic [1:0] way_t;
   typedef logic [2:0] plru_t;   // bit0 = b0 (root), bit1 = b1 (ways 0/1), bit2 = b2 (ways 2/3)

   // Tree walk: b0 picks the half, b1/b2 pick the way inside it.
   function automatic way_t plru_victim(input plru_t bits);
      way_t v;
      if (bits[0]) begin
         if (bits[2]) v = 2'd3;
         else         v = 2'd2;
      end else begin
         if (bits[1]) v = 2'd1;
         else         v = 2'd0;
      end
      return v;
   endfunction

   // Point the tree away from the way just touched.
   function automatic plru_t plru_update(input plru_t bits, input way_t w);
      plru_t n;
      n    = bits;
      n[0] = ~w[1];
      if (!w[1]) n[1] = ~w[0];
      else       n[2] = ~w[0];
      return n;
   endfunction

   // Index of the lowest set bit; 0 when none is set.
   function automatic way_t lowest_set(input logic [3:0] v);
      way_t w;
      if      (v[0]) w = 2'd0;
      else if (v[1]) w = 2'd1;
      else if (v[2]) w = 2'd2;
      else if (v[3]) w = 2'd3;
      else           w = 2'd0;
      return w;
   endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set tree pseudo-LRU state: one 3-bit tree per set, combinational
// victim read and single-port update, all trees cleared by reset.
module cache_plru #(
   parameter int IDX_W = cache_ctrl_pkg::INDEX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] i_index,
   output logic [1:0]       o_victim,
   input  logic             i_upd_en,
   input  logic [1:0]       i_upd_way
);
   import cache_ctrl_pkg::*;

   localparam int SETS = 1 << IDX_W;

   plru_t r_bits [SETS];

   // Tree storage: cleared on reset, rewritten for the indexed set on access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SETS; i++) begin
            r_bits[i] <= 3'b000;
         end
      end else if (i_upd_en) begin
         r_bits[i_index] <= plru_update(r_bits[i_index], i_upd_way);
      end
   end

   assign o_victim = plru_victim(r_bits[i_index]);

endmodule

// File: rtl/cache_controller.sv
// Processor-side controller for a 4-way set-associative cache with a
// write-through, no-write-allocate policy over a simple backing RAM.
module cache_controller #(
   parameter int TAG_W       = cache_ctrl_pkg::TAG_W,
   parameter int INDEX_W     = cache_ctrl_pkg::INDEX_W,
   parameter int RAM_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   output logic [31:0]      resp_rdata,
   output logic             resp_hit,
   output logic             cache_en,
   output logic             cache_op,
   output logic [31:0]      cache_addr,
   output logic [1:0]       cache_way,
   output logic [31:0]      cache_wdata,
   input  logic [TAG_W-1:0] cache_tag0,
   input  logic [TAG_W-1:0] cache_tag1,
   input  logic [TAG_W-1:0] cache_tag2,
   input  logic [TAG_W-1:0] cache_tag3,
   input  logic             cache_valid0,
   input  logic             cache_valid1,
   input  logic             cache_valid2,
   input  logic             cache_valid3,
   input  logic [31:0]      cache_data0,
   input  logic [31:0]      cache_data1,
   input  logic [31:0]      cache_data2,
   input  logic [31:0]      cache_data3,
   output logic             ram_en,
   output logic             ram_op,
   output logic [9:0]       ram_addr,
   output logic [31:0]      ram_wdata,
   input  logic [31:0]      ram_rdata
);
   import cache_ctrl_pkg::*;

   localparam logic [3:0] LAT_LAST = 4'(RAM_LATENCY - 1);

   state_t            r_state;
   state_t            w_next_state;

   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic              r_write;
   logic              r_hit;
   way_t              r_hit_way;
   way_t              r_fill_way;
   logic [31:0]       r_fill_data;
   logic [3:0]        r_wait_cnt;
   logic [31:0]       r_resp_rdata;
   logic              r_resp_hit;

   logic [TAG_W-1:0]  w_req_tag;
   logic [3:0]        w_valid_vec;
   logic [3:0]        w_hit_vec;
   logic              w_any_hit;
   way_t              w_hit_way;
   way_t              w_inv_way;
   logic              w_any_inv;
   logic [31:0]       w_hit_data;
   way_t              w_victim;
   logic              w_plru_upd;
   way_t              w_plru_way;
   logic              w_wait_done;

   // ---------------------------------------------------------------
   // Tag compare against the set returned by the LOOKUP read
   // ---------------------------------------------------------------
   assign w_req_tag   = r_addr[31 -: TAG_W];
   assign w_valid_vec = {cache_valid3, cache_valid2, cache_valid1, cache_valid0};
   assign w_hit_vec[0] = cache_valid0 & (cache_tag0 == w_req_tag);
   assign w_hit_vec[1] = cache_valid1 & (cache_tag1 == w_req_tag);
   assign w_hit_vec[2] = cache_valid2 & (cache_tag2 == w_req_tag);
   assign w_hit_vec[3] = cache_valid3 & (cache_tag3 == w_req_tag);
   assign w_any_hit   = |w_hit_vec;
   assign w_hit_way   = lowest_set(w_hit_vec);
   assign w_any_inv   = ~(&w_valid_vec);
   assign w_inv_way   = lowest_set(~w_valid_vec);
   assign w_wait_done = (r_wait_cnt == LAT_LAST);

   // Select the data word of the winning (lowest) hit way
   always_comb begin
      w_hit_data = 32'd0;
      case (w_hit_way)
         2'd0:    w_hit_data = cache_data0;
         2'd1:    w_hit_data = cache_data1;
         2'd2:    w_hit_data = cache_data2;
         2'd3:    w_hit_data = cache_data3;
         default: w_hit_data = 32'd0;
      endcase
   end

   // PLRU is touched by a load hit, a fill, and a store that hit
   always_comb begin
      w_plru_upd = 1'b0;
      w_plru_way = 2'd0;
      case (r_state)
         S_COMPARE: begin
            w_plru_upd = ~r_write & w_any_hit;
            w_plru_way = w_hit_way;
         end
         S_FILL: begin
            w_plru_upd = 1'b1;
            w_plru_way = r_fill_way;
         end
         S_WRITE: begin
            w_plru_upd = r_hit;
            w_plru_way = r_hit_way;
         end
         default: begin
            w_plru_upd = 1'b0;
            w_plru_way = 2'd0;
         end
      endcase
   end

   cache_plru #(
      .IDX_W(INDEX_W)
   ) u_plru (
      .clk       (clk),
      .rst       (rst),
      .i_index   (r_addr[2 +: INDEX_W]),
      .o_victim  (w_victim),
      .i_upd_en  (w_plru_upd),
      .i_upd_way (w_plru_way)
   );

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) w_next_state = S_LOOKUP;
            else           w_next_state = S_IDLE;
         end
         S_LOOKUP:  w_next_state = S_COMPARE;
         S_COMPARE: begin
            if (r_write)        w_next_state = S_WRITE;
            else if (w_any_hit) w_next_state = S_RESP;
            else                w_next_state = S_MEM_RD;
         end
         S_MEM_RD:  w_next_state = S_MEM_WAIT;
         S_MEM_WAIT: begin
            if (w_wait_done) w_next_state = S_FILL;
            else             w_next_state = S_MEM_WAIT;
         end
         S_FILL:    w_next_state = S_RESP;
         S_WRITE:   w_next_state = S_RESP;
         S_RESP:    w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // Strobes decoded from the current state; held low while reset is asserted
   always_comb begin
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      cache_en    = 1'b0;
      cache_op    = 1'b0;
      cache_way   = 2'd0;
      cache_wdata = 32'd0;
      ram_en      = 1'b0;
      ram_op      = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = ~rst;
         end
         S_LOOKUP: begin
            cache_en = 1'b1;
         end
         S_MEM_RD: begin
            ram_en = 1'b1;
         end
         S_FILL: begin
            cache_en    = 1'b1;
            cache_op    = 1'b1;
            cache_way   = r_fill_way;
            cache_wdata = r_fill_data;
         end
         S_WRITE: begin
            ram_en      = 1'b1;
            ram_op      = 1'b1;
            cache_en    = r_hit;
            cache_op    = r_hit;
            cache_way   = r_hit ? r_hit_way : 2'd0;
            cache_wdata = r_hit ? r_wdata : 32'd0;
         end
         S_RESP: begin
            resp_valid = 1'b1;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------

   // Request latch, lookup results, RAM wait counter and response data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr       <= 32'd0;
         r_wdata      <= 32'd0;
         r_write      <= 1'b0;
         r_hit        <= 1'b0;
         r_hit_way    <= 2'd0;
         r_fill_way   <= 2'd0;
         r_fill_data  <= 32'd0;
         r_wait_cnt   <= 4'd0;
         r_resp_rdata <= 32'd0;
         r_resp_hit   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_addr       <= req_addr;
                  r_wdata      <= req_wdata;
                  r_write      <= req_write;
                  r_resp_rdata <= 32'd0;
                  r_resp_hit   <= 1'b0;
               end
            end
            S_COMPARE: begin
               r_hit      <= w_any_hit;
               r_hit_way  <= w_hit_way;
               r_fill_way <= w_any_inv ? w_inv_way : w_victim;
               r_resp_hit <= w_any_hit;
               if (!r_write && w_any_hit) begin
                  r_resp_rdata <= w_hit_data;
               end
            end
            S_MEM_RD: begin
               r_wait_cnt <= 4'd0;
            end
            S_MEM_WAIT: begin
               if (w_wait_done) begin
                  r_wait_cnt   <= 4'd0;
                  r_fill_data  <= ram_rdata;
                  r_resp_rdata <= ram_rdata;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 4'd1;
               end
            end
            default: begin
               r_wait_cnt <= r_wait_cnt;
            end
         endcase
      end
   end

   assign resp_rdata = r_resp_rdata;
   assign resp_hit   = r_resp_hit;
   assign cache_addr = r_addr;
   assign ram_addr   = r_addr[9:0];
   assign ram_wdata  = r_wdata;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with behavioural cache and RAM models.
module tb_cache_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_hit;
   logic [31:0] resp_rdata;
   logic        cache_en, cache_op;
   logic [31:0] cache_addr, cache_wdata;
   logic [1:0]  cache_way;
   logic [21:0] cache_tag0, cache_tag1, cache_tag2, cache_tag3;
   logic        cache_valid0, cache_valid1, cache_valid2, cache_valid3;
   logic [31:0] cache_data0, cache_data1, cache_data2, cache_data3;
   logic        ram_en, ram_op;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata, ram_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural storage
   logic [21:0] m_tag   [0:3][0:255];
   logic        m_valid [0:3][0:255];
   logic [31:0] m_data  [0:3][0:255];
   logic [31:0] ram_mem [0:255];

   // Per-request observations
   int          rc_resp_cyc, rc_resp2_cyc, rc_resp_cnt;
   int          rc_ram_rd_cyc, rc_ram_wr_cyc, rc_cache_wr_cyc, rc_cache_en_cnt, rc_ready_busy;
   logic [31:0] rc_rdata, rc_cache_wdata, rc_ram_wdata;
   logic        rc_hit;
   logic [1:0]  rc_cache_way;
   logic [9:0]  rc_ram_addr;

   cache_controller dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
      .cache_en(cache_en), .cache_op(cache_op), .cache_addr(cache_addr),
      .cache_way(cache_way), .cache_wdata(cache_wdata),
      .cache_tag0(cache_tag0), .cache_tag1(cache_tag1),
      .cache_tag2(cache_tag2), .cache_tag3(cache_tag3),
      .cache_valid0(cache_valid0), .cache_valid1(cache_valid1),
      .cache_valid2(cache_valid2), .cache_valid3(cache_valid3),
      .cache_data0(cache_data0), .cache_data1(cache_data1),
      .cache_data2(cache_data2), .cache_data3(cache_data3),
      .ram_en(ram_en), .ram_op(ram_op), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Cache and RAM models: one-cycle read, write on the sampled edge
   always @(posedge clk) begin
      if (cache_en && !cache_op) begin
         cache_tag0   <= m_tag[0][cache_addr[9:2]];   cache_valid0 <= m_valid[0][cache_addr[9:2]];
         cache_tag1   <= m_tag[1][cache_addr[9:2]];   cache_valid1 <= m_valid[1][cache_addr[9:2]];
         cache_tag2   <= m_tag[2][cache_addr[9:2]];   cache_valid2 <= m_valid[2][cache_addr[9:2]];
         cache_tag3   <= m_tag[3][cache_addr[9:2]];   cache_valid3 <= m_valid[3][cache_addr[9:2]];
         cache_data0  <= m_data[0][cache_addr[9:2]];  cache_data1  <= m_data[1][cache_addr[9:2]];
         cache_data2  <= m_data[2][cache_addr[9:2]];  cache_data3  <= m_data[3][cache_addr[9:2]];
      end
      if (cache_en && cache_op) begin
         m_tag[cache_way][cache_addr[9:2]]   = cache_addr[31:10];
         m_valid[cache_way][cache_addr[9:2]] = 1'b1;
         m_data[cache_way][cache_addr[9:2]]  = cache_wdata;
      end
      if (ram_en && !ram_op) ram_rdata <= ram_mem[ram_addr[9:2]];
      if (ram_en && ram_op)  ram_mem[ram_addr[9:2]] = ram_wdata;
   end

   task automatic preload();
      for (int w = 0; w < 4; w++) begin
         for (int s = 0; s < 256; s++) begin
            m_tag[w][s] = 22'd0; m_valid[w][s] = 1'b0; m_data[w][s] = 32'd0;
         end
      end
      for (int s = 0; s < 256; s++) ram_mem[s] = 32'd0;
      for (int w = 0; w < 4; w++) begin
         m_tag[w][10]   = 22'(10 + w);
         m_valid[w][10] = 1'b1;
         m_data[w][10]  = 32'(w * 1000);
      end
      m_tag[0][9] = 22'd7; m_valid[0][9] = 1'b1; m_data[0][9] = 32'd123;
      ram_mem[10] = 32'd777;
      ram_mem[9]  = 32'd555;
      cache_tag0 = 22'd0; cache_tag1 = 22'd0; cache_tag2 = 22'd0; cache_tag3 = 22'd0;
      cache_valid0 = 1'b0; cache_valid1 = 1'b0; cache_valid2 = 1'b0; cache_valid3 = 1'b0;
      cache_data0 = 32'd0; cache_data1 = 32'd0; cache_data2 = 32'd0; cache_data3 = 32'd0;
      ram_rdata = 32'd0;
   endtask

   // Issue one request from an IDLE cycle (entered at posedge+1) and log activity.
   // With hold=1 req_valid stays high until cycle 7 to exercise busy/back-to-back.
   task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input bit hold);
      rc_resp_cyc = -1; rc_resp2_cyc = -1; rc_resp_cnt = 0;
      rc_ram_rd_cyc = -1; rc_ram_wr_cyc = -1; rc_cache_wr_cyc = -1;
      rc_cache_en_cnt = 0; rc_ready_busy = 0;
      rc_rdata = 32'd0; rc_hit = 1'b0; rc_cache_way = 2'd0; rc_cache_wdata = 32'd0;
      rc_ram_addr = 10'd0; rc_ram_wdata = 32'd0;
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (!hold || c >= 7) req_valid = 1'b0;
         if (resp_valid) begin
            if (rc_resp_cyc < 0) begin
               rc_resp_cyc = c; rc_rdata = resp_rdata; rc_hit = resp_hit;
            end else if (rc_resp2_cyc < 0) begin
               rc_resp2_cyc = c;
            end
            rc_resp_cnt++;
         end
         if (c <= 2 && req_ready) rc_ready_busy++;
         if (ram_en && !ram_op) begin rc_ram_rd_cyc = c; rc_ram_addr = ram_addr; end
         if (ram_en && ram_op) begin rc_ram_wr_cyc = c; rc_ram_addr = ram_addr; rc_ram_wdata = ram_wdata; end
         if (cache_en && cache_op) begin rc_cache_wr_cyc = c; rc_cache_way = cache_way; rc_cache_wdata = cache_wdata; end
         if (cache_en) rc_cache_en_cnt++;
         if (!hold && resp_valid) break;
         if (hold && c >= 9) break;
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_tests++;
      if ({req_ready, resp_valid, resp_rdata, resp_hit, cache_en, cache_op, cache_addr, cache_way,
           cache_wdata, ram_en, ram_op, ram_addr, ram_wdata} !== 147'd0) begin
         n_fail++; $display("FAIL reset_outputs: got req_ready=%0b resp_valid=%0b cache_en=%0b ram_en=%0b cache_addr=%h, expected all 0",
                            req_ready, resp_valid, cache_en, ram_en, cache_addr);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", req_ready); end
      n_tests++;
      if ({resp_valid, cache_en, ram_en} !== 3'b000) begin
         n_fail++; $display("FAIL reset_strobes: got %b expected 000", {resp_valid, cache_en, ram_en});
      end
   endtask

   task automatic test_load_hit();
      run_req(1'b0, 32'd11304, 32'd0, 1'b0);
      n_tests++;
      if (rc_resp_cyc !== 3) begin n_fail++; $display("FAIL hit_latency: got %0d expected 3", rc_resp_cyc); end
      n_tests++;
      if (rc_rdata !== 32'd1000 || rc_hit !== 1'b1) begin
         n_fail++; $display("FAIL hit_data: got %0d/%0b expected 1000/1", rc_rdata, rc_hit);
      end
      n_tests++;
      if (rc_ram_rd_cyc !== -1 || rc_cache_en_cnt !== 1) begin
         n_fail++; $display("FAIL hit_side: got ram_rd_cyc=%0d cache_en_cnt=%0d expected -1/1", rc_ram_rd_cyc, rc_cache_en_cnt);
      end
   endtask

   task automatic test_load_miss();
      run_req(1'b0, 32'd14376, 32'd0, 1'b0);
      n_tests++;
      if (rc_ram_rd_cyc !== 3 || rc_ram_addr !== 10'd40) begin
         n_fail++; $display("FAIL miss_ram_read: got cyc=%0d addr=%0d expected 3/40", rc_ram_rd_cyc, rc_ram_addr);
      end
      n_tests++;
      if (rc_resp_cyc !== 6 || rc_rdata !== 32'd777 || rc_hit !== 1'b0) begin
         n_fail++; $display("FAIL miss_resp: got cyc=%0d data=%0d hit=%0b expected 6/777/0", rc_resp_cyc, rc_rdata, rc_hit);
      end
      n_tests++;
      if (rc_cache_wr_cyc !== 5 || rc_cache_way !== 2'd2 || rc_cache_wdata !== 32'd777) begin
         n_fail++; $display("FAIL miss_fill: got cyc=%0d way=%0d data=%0d expected 5/2/777", rc_cache_wr_cyc, rc_cache_way, rc_cache_wdata);
      end
      n_tests++;
      if (m_tag[2][10] !== 22'd14 || m_data[2][10] !== 32'd777) begin
         n_fail++; $display("FAIL miss_fill_content: got tag=%0d data=%0d expected 14/777", m_tag[2][10], m_data[2][10]);
      end
   endtask

   task automatic test_invalid_first();
      run_req(1'b0, 32'd5156, 32'd0, 1'b0);
      n_tests++;
      if (rc_cache_way !== 2'd1 || rc_cache_wr_cyc !== 5) begin
         n_fail++; $display("FAIL invalid_first_way: got way=%0d cyc=%0d expected 1/5", rc_cache_way, rc_cache_wr_cyc);
      end
      n_tests++;
      if (rc_rdata !== 32'd555 || rc_resp_cyc !== 6) begin
         n_fail++; $display("FAIL invalid_first_resp: got data=%0d cyc=%0d expected 555/6", rc_rdata, rc_resp_cyc);
      end
   endtask

   task automatic test_store_hit();
      run_req(1'b1, 32'd13352, 32'd4242, 1'b0);
      n_tests++;
      if (rc_cache_wr_cyc !== 3 || rc_cache_way !== 2'd3 || rc_cache_wdata !== 32'd4242) begin
         n_fail++; $display("FAIL store_hit_cache: got cyc=%0d way=%0d data=%0d expected 3/3/4242", rc_cache_wr_cyc, rc_cache_way, rc_cache_wdata);
      end
      n_tests++;
      if (rc_ram_wr_cyc !== 3 || rc_ram_addr !== 10'd40 || rc_ram_wdata !== 32'd4242) begin
         n_fail++; $display("FAIL store_hit_ram: got cyc=%0d addr=%0d data=%0d expected 3/40/4242", rc_ram_wr_cyc, rc_ram_addr, rc_ram_wdata);
      end
      n_tests++;
      if (rc_resp_cyc !== 4 || rc_hit !== 1'b1 || rc_rdata !== 32'd0) begin
         n_fail++; $display("FAIL store_hit_resp: got cyc=%0d hit=%0b data=%0d expected 4/1/0", rc_resp_cyc, rc_hit, rc_rdata);
      end
      run_req(1'b0, 32'd13352, 32'd0, 1'b0);
      n_tests++;
      if (rc_rdata !== 32'd4242 || rc_hit !== 1'b1 || rc_resp_cyc !== 3) begin
         n_fail++; $display("FAIL store_readback: got data=%0d hit=%0b cyc=%0d expected 4242/1/3", rc_rdata, rc_hit, rc_resp_cyc);
      end
   endtask

   task automatic test_store_miss();
      run_req(1'b1, 32'd20520, 32'd99, 1'b0);
      n_tests++;
      if (rc_ram_wr_cyc !== 3 || rc_ram_wdata !== 32'd99 || ram_mem[10] !== 32'd99) begin
         n_fail++; $display("FAIL store_miss_ram: got cyc=%0d data=%0d mem=%0d expected 3/99/99", rc_ram_wr_cyc, rc_ram_wdata, ram_mem[10]);
      end
      n_tests++;
      if (rc_cache_en_cnt !== 1 || rc_cache_wr_cyc !== -1) begin
         n_fail++; $display("FAIL store_miss_cache: got cache_en_cnt=%0d wr_cyc=%0d expected 1/-1", rc_cache_en_cnt, rc_cache_wr_cyc);
      end
      n_tests++;
      if (rc_hit !== 1'b0 || rc_resp_cyc !== 4) begin
         n_fail++; $display("FAIL store_miss_resp: got hit=%0b cyc=%0d expected 0/4", rc_hit, rc_resp_cyc);
      end
   endtask

   task automatic test_back_to_back();
      run_req(1'b0, 32'd11304, 32'd0, 1'b1);
      n_tests++;
      if (rc_ready_busy !== 0) begin n_fail++; $display("FAIL busy_ready: got %0d ready cycles expected 0", rc_ready_busy); end
      n_tests++;
      if (rc_resp_cyc !== 3 || rc_resp2_cyc !== 7 || rc_resp_cnt !== 2) begin
         n_fail++; $display("FAIL back_to_back: got resp at %0d,%0d count %0d expected 3,7 count 2", rc_resp_cyc, rc_resp2_cyc, rc_resp_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int activity;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd30760; req_wdata = 32'd0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
      end
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({req_ready, resp_valid, resp_rdata, resp_hit, cache_en, cache_op, cache_addr, cache_way,
           cache_wdata, ram_en, ram_op, ram_addr, ram_wdata} !== 147'd0) begin
         n_fail++; $display("FAIL midreset_outputs: got req_ready=%0b cache_addr=%h ram_addr=%0d, expected all 0",
                            req_ready, cache_addr, ram_addr);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %0b expected 1", req_ready); end
      activity = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (resp_valid || cache_en || ram_en) activity++;
      end
      n_tests++;
      if (activity !== 0) begin n_fail++; $display("FAIL midreset_dropped: got %0d active cycles expected 0", activity); end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      preload();
      test_reset();
      test_load_hit();
      test_load_miss();
      test_invalid_first();
      test_store_hit();
      test_store_miss();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
